// File: rtl/demux_router.sv
// Registered 1-to-NLANES demultiplexer with per-lane valid/ready holding registers.
// Optional broadcast on in_sel = 4'hF is enabled by defining DEMUX_BROADCAST_EN.
module demux_router #(
    parameter int WIDTH  = 16,
    parameter int NLANES = 12,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [3:0]                in_sel,
    output logic [NLANES-1:0]         out_valid,
    input  logic [NLANES-1:0]         out_ready,
    output logic [NLANES*WIDTH-1:0]   out_data,
    output logic                      err_sel,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      err_clr
);

    logic [NLANES-1:0]       can_accept;
    logic [NLANES-1:0]       lane_wr;
    logic                    sel_valid;
    logic                    sel_ready;
    logic                    bcast;
    logic                    accept;
    logic                    drop;
    logic [NLANES-1:0]       valid_q;
    logic [NLANES*WIDTH-1:0] data_q;
    logic                    err_q;
    logic [CNT_W-1:0]        cnt_q;

    // A full lane can still take a word when its consumer drains in the same cycle.
    assign can_accept = ~valid_q | out_ready;
    assign sel_valid  = (in_sel < 4'(NLANES));

`ifdef DEMUX_BROADCAST_EN
    assign bcast = (in_sel == 4'hF);
`else
    assign bcast = 1'b0;
`endif

    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < NLANES; k++) begin
            if (in_sel == 4'(k)) begin
                sel_ready = can_accept[k];
            end
        end
    end

    always_comb begin
        if (bcast) begin
            in_ready = &can_accept;
        end else if (sel_valid) begin
            in_ready = sel_ready;
        end else begin
            in_ready = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~sel_valid & ~bcast;

    always_comb begin
        lane_wr = '0;
        for (int k = 0; k < NLANES; k++) begin
            lane_wr[k] = accept & (bcast | (sel_valid & (in_sel == 4'(k))));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < NLANES; k++) begin
                if (lane_wr[k]) begin
                    valid_q[k]                <= 1'b1;
                    data_q[k*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // A drop coinciding with err_clr leaves the flag clear but still counts once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else if (err_clr) begin
            err_q <= 1'b0;
            cnt_q <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            err_q <= 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_sel   = err_q;
    assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: vector table plus scoreboard of routed words.
module tb_demux_router;

    localparam int WIDTH  = 16;
    localparam int NLANES = 12;
    localparam int CNT_W  = 8;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic [3:0]              in_sel;
    logic [NLANES-1:0]       out_valid;
    logic [NLANES-1:0]       out_ready;
    logic [NLANES*WIDTH-1:0] out_data;
    logic                    err_sel;
    logic [CNT_W-1:0]        drop_cnt;
    logic                    err_clr;

    demux_router #(.WIDTH(WIDTH), .NLANES(NLANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel),
        .drop_cnt  (drop_cnt),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        sel;
        logic [WIDTH-1:0]  data;
        logic [NLANES-1:0] ordy;
        logic              exp_rdy;
        logic [NLANES-1:0] exp_valid;
        logic [CNT_W-1:0]  exp_cnt;
        logic              exp_err;
    } vec_t;

    typedef struct {
        int               lane;
        logic [WIDTH-1:0] data;
    } sb_t;

    vec_t vecs[11];
    sb_t  exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane_data(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    // Drives one word for one clock; pushes the expected lane contents when accepted.
    task automatic send(input logic [3:0] sel, input logic [WIDTH-1:0] data,
                        input logic exp_rdy, input string name);
        sb_t e;
        bit  pushed;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        #1;
        chk({name, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        pushed = exp_rdy && (sel < NLANES);
        if (pushed) begin
            e.lane = int'(sel);
            e.data = data;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (pushed) begin
            e = exp_q.pop_front();
            chk({name, "_lane_valid"}, 32'(out_valid[e.lane]), 32'd1);
            chk({name, "_lane_data"}, 32'(lane_data(e.lane)), 32'(e.data));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'd3,  16'h1234, 12'h000, 1'b1, 12'h008, 8'd0, 1'b0};
        vecs[1]  = '{4'd3,  16'h5555, 12'h000, 1'b0, 12'h008, 8'd0, 1'b0};
        vecs[2]  = '{4'd3,  16'h5555, 12'h008, 1'b1, 12'h008, 8'd0, 1'b0};
        vecs[3]  = '{4'd0,  16'h0A0A, 12'h000, 1'b1, 12'h009, 8'd0, 1'b0};
        vecs[4]  = '{4'd11, 16'hB00B, 12'h000, 1'b1, 12'h809, 8'd0, 1'b0};
        vecs[5]  = '{4'd3,  16'h6666, 12'h000, 1'b0, 12'h809, 8'd0, 1'b0};
        vecs[6]  = '{4'd3,  16'h6666, 12'h008, 1'b1, 12'h809, 8'd0, 1'b0};
        vecs[7]  = '{4'd12, 16'hDEAD, 12'h000, 1'b1, 12'h809, 8'd1, 1'b1};
        vecs[8]  = '{4'd13, 16'hBEEF, 12'h000, 1'b1, 12'h809, 8'd2, 1'b1};
        vecs[9]  = '{4'd14, 16'hF00D, 12'h000, 1'b1, 12'h809, 8'd3, 1'b1};
        vecs[10] = '{4'd5,  16'h0505, 12'h008, 1'b1, 12'h821, 8'd3, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data_zero", 32'(out_data == '0), 32'd1);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_err_sel", 32'(err_sel), 32'd0);
        for (int s = 0; s < 16; s++) begin
            in_sel = 4'(s);
            #1;
            chk($sformatf("idle_in_ready_sel%0d", s), 32'(in_ready), 32'd1);
        end

        for (int i = 0; i < 11; i++) begin
            out_ready = vecs[i].ordy;
            send(vecs[i].sel, vecs[i].data, vecs[i].exp_rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_err_sel", i), 32'(err_sel), 32'(vecs[i].exp_err));
        end
        chk("lane3_held_after_drain", 32'(lane_data(3)), 32'h6666);
        out_ready = '0;

        // err_clr together with a drop: flag clear, count restarts at one
        in_valid = 1'b1;
        in_sel   = 4'd12;
        err_clr  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        chk("clr_drop_err_sel", 32'(err_sel), 32'd0);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);

        out_ready = 12'h008;
        send(4'd3, 16'hAAAA, 1'b1, "b2b_0");
        send(4'd3, 16'hBBBB, 1'b1, "b2b_1");
        send(4'd3, 16'hCCCC, 1'b1, "b2b_2");
        @(posedge clk);
        #1;
        chk("b2b_drained_valid", 32'(out_valid), 32'h821);
        chk("b2b_drained_data", 32'(lane_data(3)), 32'hCCCC);
        out_ready = '0;

        in_valid = 1'b1;
        in_sel   = 4'd13;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
        chk("sat_err_sel", 32'(err_sel), 32'd1);
        chk("sat_lanes_unchanged", 32'(out_valid), 32'h821);

        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_cnt", 32'(drop_cnt), 32'd0);
        chk("clr_err", 32'(err_sel), 32'd0);

        out_ready = '1;
        @(posedge clk);
        #1;
        out_ready = '0;
        chk("drain_all", 32'(out_valid), 32'h0);
        send(4'd5, 16'h0505, 1'b1, "stall5");

        in_valid = 1'b1;
        in_sel   = 4'hF;
        in_data  = 16'h5A5A;
        #1;
`ifdef DEMUX_BROADCAST_EN
        chk("bcast_stalled_ready", 32'(in_ready), 32'd0);
        out_ready[5] = 1'b1;
        #1;
        chk("bcast_released_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = '0;
        chk("bcast_valid", 32'(out_valid), 32'hFFF);
        for (int k = 0; k < NLANES; k++) begin
            chk($sformatf("bcast_lane%0d", k), 32'(lane_data(k)), 32'h5A5A);
        end
        chk("bcast_cnt", 32'(drop_cnt), 32'd0);
        chk("bcast_err", 32'(err_sel), 32'd0);
`else
        chk("sel15_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("sel15_valid", 32'(out_valid), 32'h020);
        chk("sel15_cnt", 32'(drop_cnt), 32'd1);
        chk("sel15_err", 32'(err_sel), 32'd1);
`endif

        out_ready = '1;
        @(posedge clk);
        #1;
        out_ready = '0;
        send(4'd0, 16'h00AA, 1'b1, "pre_rst0");
        send(4'd11, 16'h0BBB, 1'b1, "pre_rst11");
        chk("pre_rst_valid", 32'(out_valid), 32'h801);

        // Reset lands between clock edges; outputs must clear without a clock
        in_valid = 1'b1;
        in_sel   = 4'd12;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_data_zero", 32'(out_data == '0), 32'd1);
        chk("async_rst_cnt", 32'(drop_cnt), 32'd0);
        chk("async_rst_err", 32'(err_sel), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Registered 1-to-12 demultiplexer: the write-side counterpart of the team's 16-bit 12:1 result-select mux.
- Accepts one 16-bit word plus a 4-bit destination select per handshake and steers it into one of 12 per-lane holding registers.
- Each lane drains independently via its own valid/ready handshake.
- Out-of-range selects are dropped, flagged and counted.

Parameters:
- WIDTH, 16, data width of the input word and of each lane.
- NLANES, 12, number of output lanes; legal range 1..15; lane index = select value.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assert asynchronously, deassert synchronous to clk.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid is also high (combinational).
- in_data  input  WIDTH  word to route.
- in_sel  input  4  destination lane index.
- out_valid  output  NLANES  per-lane holding register occupied.
- out_ready  input  NLANES  per-lane consumer accepts.
- out_data  output  NLANES*WIDTH  packed lane data; lane k occupies bits [k*WIDTH +: WIDTH].
- err_sel  output  1  sticky: an out-of-range select was dropped.
- drop_cnt  output  CNT_W  saturating count of dropped words.
- err_clr  input  1  synchronous clear of err_sel and drop_cnt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0.
  - Any held words are discarded; there is no recovery after reset.
- Lane k can accept when out_valid[k] = 0 or out_ready[k] = 1 (pass-through replace).
- in_ready:
  - If in_sel < NLANES, in_ready = lane in_sel can accept.
  - If in_sel >= NLANES, in_ready = 1 (the word is sunk).
  - in_ready depends only on in_sel, out_valid and out_ready, never on in_valid.
- Accept (in_valid & in_ready) with a valid select:
  - Next cycle: out_data[lane] = in_data and out_valid[lane] = 1.
  - Latency is 1 clock from accept to out_valid.
  - Other lanes are unaffected.
- Lane drain (out_valid[k] & out_ready[k]) with no same-cycle write to lane k: out_valid[k] = 0 next cycle; out_data[k] holds its last value.
- Simultaneous drain and write on the same lane: out_valid stays 1, out_data takes the new word, and no bubble is inserted.
- Accept with an invalid select:
  - No lane changes.
  - err_sel = 1 next cycle.
  - drop_cnt increments and saturates at 2^CNT_W - 1 (no wrap).
- err_clr:
  - err_clr = 1 clears err_sel and drop_cnt next cycle.
  - If a drop occurs in the same cycle as err_clr, err_clr wins for err_sel, and drop_cnt = 1.
- Producer rules:
  - in_data and in_sel must stay stable while in_valid = 1 and in_ready = 0.
  - Producer must not deassert in_valid before the accept.
- Consumer rules: out_data[k] is stable while out_valid[k] = 1 and out_ready[k] = 0.
- Throughput:
  - One word per clock sustained to any lane whose consumer holds out_ready = 1.
  - Lanes are fully independent; a stalled lane blocks the input only when the input is addressed to it (head-of-line).

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- When defined, in_sel = 4'hF is a broadcast:
  - in_ready = AND over all lanes of "can accept".
  - On accept, every lane loads in_data and sets out_valid.
  - Broadcast is not counted as a drop.
- When undefined, 4'hF is treated like any other out-of-range select: sunk, err_sel set, drop_cnt incremented.
- NLANES must be <= 15 in both builds.

Test Plan:
- Reset, then idle: out_valid = 0, out_data = 0, drop_cnt = 0, in_ready = 1 for every in_sel.
- Route 0x1234 to sel 3 with out_ready = 0: out_valid = 12'h008 one cycle later, out_data lane 3 = 0x1234. A second word to sel 3 sees in_ready = 0 until out_ready[3] pulses.
- Back-to-back writes to sel 3 with out_ready[3] = 1: words 0xAAAA, 0xBBBB, 0xCCCC appear on lane 3 on consecutive cycles, and out_valid[3] stays 1 throughout.
- sel 12, 13 and 14 each sent once: in_ready = 1, no lane changes, err_sel = 1, drop_cnt = 3. Pulse err_clr with a simultaneous drop: err_sel = 0, drop_cnt = 1.
- 300 invalid-select words: drop_cnt saturates at 255. Assert rst_n low mid-stream with lanes 0 and 11 full: all out_valid = 0 immediately, without waiting for a clock.
- With DEMUX_BROADCAST_EN, sel 15 with lane 5 stalled: in_ready = 0. Release lane 5: all 12 lanes load 0x5A5A, out_valid = 12'hFFF, drop_cnt unchanged. Without the macro, the same word increments drop_cnt.
